qed_i_cache: RTL and testbench
==============================

# qed_i_cache

Duplicate-instruction buffer for the SQED front end, sitting directly upstream of the QED instruction mux. Each original instruction issued in original mode has its register-remapped duplicate, supplied by the QED decoder/rewriter, pushed into an in-order FIFO. When duplicate execution is selected, the block replays the buffered duplicates in program order. It drives the mux's `qed_instruction` and `exec_dup` inputs and reports the orig/dup balance used by the QED consistency check.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `IW`, 32: instruction width.
- `CNT_W`, 8: width of the issue counters.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `ena`  in  1  QED enable; low = block inert, state held
- `vld`  in  1  an instruction is issued from the IFU this cycle
- `stall`  in  1  pipeline stall; no push/pop while high
- `qed_instruction_in`  in  IW  duplicate (rewritten) form of the current original instruction
- `exec_dup`  in  1  free (symbolic) request to issue a duplicate
- `qed_instruction`  out  IW  FIFO head, to the mux
- `exec_dup_out`  out  1  qualified duplicate select, to the mux
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `num_orig`  out  CNT_W  originals recorded
- `num_dup`  out  CNT_W  duplicates issued
- `qed_ovf`  out  1  sticky: an original was lost or a counter saturated
- `qed_ready`  out  1  check point: balanced and nonzero

## Operation
- `exec_dup_out = ena & !empty & (exec_dup | full)`. The `| full` term is present only with the macro; see Configuration.
- Push when `ena & vld & !stall & !exec_dup_out & !full`. Writes `qed_instruction_in` at the tail and increments `num_orig`.
- Pop when `ena & vld & !stall & exec_dup_out`. Advances the head and increments `num_dup`.
- Push and pop are mutually exclusive by construction.
- `qed_instruction` = head entry (show-ahead). Value is don't-care when `empty`; output 0 in that case for determinism.
- Counters saturate at 2^CNT_W−1. Reaching saturation sets `qed_ovf`.
- `qed_ready = !qed_ovf & (num_orig == num_dup) & (num_orig != 0) & empty`.
- `ena` low: no push, no pop, `exec_dup_out`=0; pointers and counters hold.
- Reset on `rst`, including mid-replay: pointers cleared, counters cleared, `qed_ovf` cleared.
- Reset values of outputs: `empty`=1, `full`=0, `exec_dup_out`=0, `qed_instruction`=0, `num_orig`=0, `num_dup`=0, `qed_ovf`=0, `qed_ready`=0.

## Timing
- Pointers and count use DEPTH+1 occupancy encoding; wrap modulo DEPTH.
- A push at cycle t makes the entry visible at the head in t+1 if the FIFO was empty.
- `exec_dup_out` can assert at t+1 at the earliest after the first push.
- `exec_dup_out`, `full`, `empty` and `qed_instruction` are combinational from registered state and `exec_dup`; no registered latency is added. The mux consumes them in the same cycle.
- `qed_ready` is a registered-state function and is valid the cycle after the balancing pop.
- `stall` high freezes all state, even with `vld` high.

## Configuration
- `QED_FORCE_DRAIN_EN` defined:
  - `full` forces `exec_dup_out`=1 regardless of `exec_dup`.
  - No original is ever lost.
  - `qed_ovf` is set only by counter saturation.
- Not defined:
  - `exec_dup_out` follows `exec_dup` only.
  - An original issued (`vld & !stall & !exec_dup_out`) while `full` is not recorded and sets `qed_ovf`.

## Structure
- Shared package `qed_pkg`: `QED_IW`, `QED_DEPTH_DEF`, `QED_CNT_W_DEF`, and the NOP encoding constant.
- One sub-module: `qed_fifo`, a parameterised show-ahead synchronous FIFO with push/pop/full/empty.
- The control logic, counters and flags live in `qed_i_cache`.

## Test plan
- Reset, then 3 pushes of 0xA1, 0xA2, 0xA3 with `exec_dup`=0, then `exec_dup`=1 for 3 cycles -> `exec_dup_out`=1 for 3 cycles, `qed_instruction` = A1, A2, A3 in order, `qed_ready`=1 on the next cycle.
- `exec_dup`=1 while `empty` -> `exec_dup_out`=0, instruction is pushed, `num_orig`=1.
- DEPTH=4, 4 pushes, `exec_dup`=0, `vld`=1:
  - With macro: `exec_dup_out`=1 and the next cycle pops.
  - Without macro: the 5th original sets `qed_ovf`=1 and `qed_ready` stays 0.
- `stall`=1 with `vld`=1 and `exec_dup`=1 on a non-empty FIFO -> head, `num_dup` and pointers unchanged.
- 2 pushes, 1 pop, then `rst`=1 for 1 cycle -> next cycle `empty`=1, counters 0, `exec_dup_out`=0.
- `ena`=0 with `vld`=1 for 5 cycles -> no state change, `exec_dup_out`=0.

Source files
------------

// File: rtl/qed_pkg.sv
// Shared constants for the SQED duplicate-instruction buffer.
package qed_pkg;

    localparam int QED_IW        = 32;
    localparam int QED_DEPTH_DEF = 16;
    localparam int QED_CNT_W_DEF = 8;

    // RISC-V canonical NOP (addi x0, x0, 0).
    localparam logic [QED_IW-1:0] QED_NOP = 32'h0000_0013;

endpackage

// File: rtl/qed_i_cache_if.sv
// IFU/mux-side signal bundle of qed_i_cache; master drives requests, slave is the cache.
interface qed_i_cache_if
    import qed_pkg::*;
#(
    parameter int IW    = QED_IW,
    parameter int CNT_W = QED_CNT_W_DEF
);
    logic             ena;
    logic             vld;
    logic             stall;
    logic [IW-1:0]    qed_instruction_in;
    logic             exec_dup;
    logic [IW-1:0]    qed_instruction;
    logic             exec_dup_out;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] num_orig;
    logic [CNT_W-1:0] num_dup;
    logic             qed_ovf;
    logic             qed_ready;

    modport master (
        output ena, vld, stall, qed_instruction_in, exec_dup,
        input  qed_instruction, exec_dup_out, full, empty,
        input  num_orig, num_dup, qed_ovf, qed_ready
    );

    modport slave (
        input  ena, vld, stall, qed_instruction_in, exec_dup,
        output qed_instruction, exec_dup_out, full, empty,
        output num_orig, num_dup, qed_ovf, qed_ready
    );
endinterface

// File: rtl/qed_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module qed_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = QED_DEPTH_DEF,
    parameter int W     = QED_IW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full)  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop  && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all flops sample pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; empty masks stale entries at the head.
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/qed_i_cache.sv
// Duplicate-instruction buffer feeding the QED instruction mux.
// Define QED_FORCE_DRAIN_EN to force replay whenever the buffer is full.
module qed_i_cache
    import qed_pkg::*;
#(
    parameter int DEPTH = QED_DEPTH_DEF,
    parameter int IW    = QED_IW,
    parameter int CNT_W = QED_CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    qed_i_cache_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fifo_full, fifo_empty;
    logic             issue, push, pop, lost;
    logic [CNT_W-1:0] num_orig_q, num_orig_d;
    logic [CNT_W-1:0] num_dup_q,  num_dup_d;
    logic             qed_ovf_q,  qed_ovf_d;

    assign issue = bus.ena & bus.vld & ~bus.stall;

`ifdef QED_FORCE_DRAIN_EN
    assign bus.exec_dup_out = bus.ena & ~fifo_empty & (bus.exec_dup | fifo_full);
    assign lost             = 1'b0;
`else
    assign bus.exec_dup_out = bus.ena & ~fifo_empty & bus.exec_dup;
    // An original issued while the buffer is full has no slot and is dropped.
    assign lost             = issue & ~bus.exec_dup_out & fifo_full;
`endif

    assign push = issue & ~bus.exec_dup_out & ~fifo_full;
    assign pop  = issue &  bus.exec_dup_out;

    qed_fifo #(
        .DEPTH (DEPTH),
        .W     (IW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.qed_instruction_in),
        .dout  (bus.qed_instruction),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        num_orig_d = num_orig_q;
        num_dup_d  = num_dup_q;
        if (push && num_orig_q != CNT_MAX) num_orig_d = num_orig_q + CNT_W'(1);
        if (pop  && num_dup_q  != CNT_MAX) num_dup_d  = num_dup_q  + CNT_W'(1);
        qed_ovf_d = qed_ovf_q | lost | (num_orig_d == CNT_MAX) | (num_dup_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_orig_q <= '0;
            num_dup_q  <= '0;
            qed_ovf_q  <= 1'b0;
        end else begin
            num_orig_q <= num_orig_d;
            num_dup_q  <= num_dup_d;
            qed_ovf_q  <= qed_ovf_d;
        end
    end

    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.num_orig  = num_orig_q;
    assign bus.num_dup   = num_dup_q;
    assign bus.qed_ovf   = qed_ovf_q;
    assign bus.qed_ready = ~qed_ovf_q & (num_orig_q == num_dup_q) &
                           (num_orig_q != '0) & fifo_empty;
endmodule

// File: tb/tb_qed_i_cache.sv
// Directed self-checking bench for qed_i_cache (DEPTH=4); expectations follow QED_FORCE_DRAIN_EN.
module tb_qed_i_cache;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    qed_i_cache_if #(.IW(32), .CNT_W(8)) bus ();

    qed_i_cache #(
        .DEPTH (4),
        .IW    (32),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic v, input logic s, input logic x,
                         input logic [31:0] ins);
        bus.ena                = e;
        bus.vld                = v;
        bus.stall              = s;
        bus.exec_dup           = x;
        bus.qed_instruction_in = ins;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_empty",    32'(bus.empty),           32'd1);
        check("rst_full",     32'(bus.full),            32'd0);
        check("rst_dup_out",  32'(bus.exec_dup_out),    32'd0);
        check("rst_instr",    bus.qed_instruction,      32'h0);
        check("rst_num_orig", 32'(bus.num_orig),        32'd0);
        check("rst_num_dup",  32'(bus.num_dup),         32'd0);
        check("rst_ovf",      32'(bus.qed_ovf),         32'd0);
        check("rst_ready",    32'(bus.qed_ready),       32'd0);
        rst = 1'b0;

        // Three originals, then three in-order replays
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA1); tick();
        check("t1_head_after_first_push", bus.qed_instruction, 32'hA1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA2); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA3); tick();
        check("t1_num_orig", 32'(bus.num_orig), 32'd3);
        check("t1_ready_unbalanced", 32'(bus.qed_ready), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        check("t1_dup_out_0", 32'(bus.exec_dup_out), 32'd1);
        check("t1_instr_0",   bus.qed_instruction,   32'hA1);
        tick();
        check("t1_dup_out_1", 32'(bus.exec_dup_out), 32'd1);
        check("t1_instr_1",   bus.qed_instruction,   32'hA2);
        tick();
        check("t1_dup_out_2", 32'(bus.exec_dup_out), 32'd1);
        check("t1_instr_2",   bus.qed_instruction,   32'hA3);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_num_dup",  32'(bus.num_dup),      32'd3);
        check("t1_empty",    32'(bus.empty),        32'd1);
        check("t1_dup_off",  32'(bus.exec_dup_out), 32'd0);
        check("t1_ready",    32'(bus.qed_ready),    32'd1);

        // exec_dup while empty: original is recorded instead
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hB1);
        check("t2_dup_out_empty", 32'(bus.exec_dup_out), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hB2);
        check("t2_num_orig", 32'(bus.num_orig),    32'd1);
        check("t2_head",     bus.qed_instruction,  32'hB1);

        // Stall freezes everything on a non-empty buffer
        tick();
        tick();
        check("st_head",     bus.qed_instruction, 32'hB1);
        check("st_num_dup",  32'(bus.num_dup),    32'd0);
        check("st_num_orig", 32'(bus.num_orig),   32'd1);
        check("st_empty",    32'(bus.empty),      32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("st_pop_num_dup", 32'(bus.num_dup),   32'd1);
        check("st_pop_ready",   32'(bus.qed_ready), 32'd1);

        // Reset in the middle of replay
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC1); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC2); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);  tick();
        check("mr_head_c2", bus.qed_instruction, 32'hC2);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("mr_empty",    32'(bus.empty),        32'd1);
        check("mr_num_orig", 32'(bus.num_orig),     32'd0);
        check("mr_num_dup",  32'(bus.num_dup),      32'd0);
        check("mr_dup_out",  32'(bus.exec_dup_out), 32'd0);

        // ena low: inert for five cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hD1); tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hD2); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hDD);
        for (int i = 0; i < 5; i++) begin
            check("en_dup_out", 32'(bus.exec_dup_out), 32'd0);
            tick();
        end
        check("en_num_orig", 32'(bus.num_orig),    32'd2);
        check("en_num_dup",  32'(bus.num_dup),     32'd0);
        check("en_head",     bus.qed_instruction,  32'hD1);

        // Full buffer behaviour
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hE0 + 32'(i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hE5);
        check("fu_full",     32'(bus.full),     32'd1);
        check("fu_num_orig", 32'(bus.num_orig), 32'd4);
`ifdef QED_FORCE_DRAIN_EN
        check("fu_forced_dup", 32'(bus.exec_dup_out), 32'd1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("fu_num_dup",  32'(bus.num_dup),     32'd1);
        check("fu_head_e2",  bus.qed_instruction,  32'hE2);
        check("fu_not_full", 32'(bus.full),        32'd0);
        check("fu_no_ovf",   32'(bus.qed_ovf),     32'd0);
`else
        check("fu_no_dup", 32'(bus.exec_dup_out), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
        check("fu_ovf",      32'(bus.qed_ovf),     32'd1);
        check("fu_orig_kept", 32'(bus.num_orig),   32'd4);
        check("fu_head_e1",  bus.qed_instruction,  32'hE1);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("fu_drained_dup", 32'(bus.num_dup),   32'd4);
        check("fu_empty",       32'(bus.empty),     32'd1);
        check("fu_ready_low",   32'(bus.qed_ready), 32'd0);
`endif

        // Counter saturation at 255
        do_reset();
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'(i)); tick();
            drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);  tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sa_orig_254", 32'(bus.num_orig),  32'd254);
        check("sa_dup_254",  32'(bus.num_dup),   32'd254);
        check("sa_ovf_0",    32'(bus.qed_ovf),   32'd0);
        check("sa_ready_1",  32'(bus.qed_ready), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hF0); tick();
        check("sa_orig_255", 32'(bus.num_orig), 32'd255);
        check("sa_ovf_1",    32'(bus.qed_ovf),  32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);  tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sa_dup_255",  32'(bus.num_dup),   32'd255);
        check("sa_ready_0",  32'(bus.qed_ready), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hF1); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("sa_orig_hold", 32'(bus.num_orig),        32'd255);
        check("sa_push_kept", bus.qed_instruction,      32'hF1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
